tone_pattern_detector: RTL and testbench

- Listens to a buzzer-drive line, such as the two-tone alarm output.
- Measures the period of the incoming square wave and classifies each period as tone 1, tone 2 or no tone.
- Detects the alarm pattern: tones alternating at the tempo rate. It asserts `alarm_detected` while that pattern persists.
- Serves as the receive-side counterpart of the alarm tone generator, for on-board self-check and for loopback verification of the alarm timer.

---
 rtl/tone_pattern_detector.sv | 215 +++++++++++++++++++++
 tb/tb_tone_pattern_detector.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tone_pattern_detector
//  Purpose  : Receive-side monitor for a two-tone alarm buzzer line. It
//             measures the rising-to-rising period of tone_in, classifies
//             each period as tone 1, tone 2 or no tone, and flags the alarm
//             pattern (tones alternating at the tempo rate).
//  Ports    : clk            - system clock (single domain)
//             rst_n          - asynchronous active-low reset
//             tone_in        - asynchronous square-wave input
//             period         - last measured period in clk cycles
//             period_valid   - one-cycle pulse when period updates
//             tone_id        - locked tone: 0 none, 1 tone 1, 2 tone 2
//             switch_count   - tone switches in current pattern (sat. 255)
//             alarm_detected - high while the alarm pattern holds
//  Revision : 1.0 - initial release
// ============================================================================
module tone_pattern_detector #(
   parameter int unsigned IN_CLK       = 50_000_000,
   parameter int unsigned FREQ1_HZ     = 1000,
   parameter int unsigned FREQ2_HZ     = 8000,
   parameter int unsigned TEMPO_HZ     = 4,
   parameter int unsigned TOL_PCT      = 10,
   parameter int unsigned MIN_CYCLES   = 4,
   parameter int unsigned SWITCHES_REQ = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tone_in,
   output logic [31:0] period,
   output logic        period_valid,
   output logic [1:0]  tone_id,
   output logic [7:0]  switch_count,
   output logic        alarm_detected
);

   localparam logic [31:0] c_p1      = 32'(IN_CLK / FREQ1_HZ);
   localparam logic [31:0] c_p2      = 32'(IN_CLK / FREQ2_HZ);
   localparam logic [31:0] c_t1      = 32'((64'(c_p1) * TOL_PCT) / 100);
   localparam logic [31:0] c_t2      = 32'((64'(c_p2) * TOL_PCT) / 100);
   localparam logic [31:0] c_per_max = 32'(64'(c_p1) * 2);
   localparam logic [31:0] c_seg_max = 32'((64'(IN_CLK) * 2) / TEMPO_HZ);
   localparam int          c_run_w   = (MIN_CYCLES < 1) ? 1 : $clog2(MIN_CYCLES + 1);
   localparam logic [c_run_w-1:0] c_min = c_run_w'(MIN_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ALARM = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Input synchronizer and registered rising-edge detect
   // ---------------------------------------------------------------------
   logic r_sync1, r_sync2, r_sync2_d, r_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync2_d <= 1'b0;
         r_rise    <= 1'b0;
      end else begin
         r_sync1   <= tone_in;
         r_sync2   <= r_sync1;
         r_sync2_d <= r_sync2;
         r_rise    <= r_sync2 & ~r_sync2_d;
      end
   end

   // ---------------------------------------------------------------------
   // Period counter. r_cnt restarts at 1 on a rise, so at the next rise it
   // holds exactly the number of cycles between the two rises.
   // ---------------------------------------------------------------------
   logic [31:0] r_cnt;
   logic        r_ref_valid;
   logic        w_timeout;

   // A rise in the saturation cycle takes priority over the timeout.
   assign w_timeout = r_ref_valid && !r_rise && (r_cnt == c_per_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_ref_valid  <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (r_rise) begin
            r_cnt       <= 32'd1;
            r_ref_valid <= 1'b1;
            if (r_ref_valid) begin
               period       <= r_cnt;
               period_valid <= 1'b1;
            end
         end else begin
            if (r_cnt != c_per_max)
               r_cnt <= r_cnt + 32'd1;
            if (w_timeout)
               r_ref_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Classifier and lock logic
   // ---------------------------------------------------------------------
   logic [31:0]        w_d1, w_d2;
   logic [1:0]         w_class;
   logic [1:0]         r_cand;
   logic [c_run_w-1:0] r_run, w_run_next;

   always_comb begin
      // Subtract the smaller from the larger so the distance never wraps.
      w_d1 = (period >= c_p1) ? (period - c_p1) : (c_p1 - period);
      w_d2 = (period >= c_p2) ? (period - c_p2) : (c_p2 - period);
      if (w_d1 <= c_t1)
         w_class = 2'd1;
      else if (w_d2 <= c_t2)
         w_class = 2'd2;
      else
         w_class = 2'd0;
      w_run_next = c_run_w'(1);
      if (w_class == r_cand)
         w_run_next = (r_run == c_min) ? r_run : r_run + c_run_w'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run   <= '0;
         r_cand  <= 2'd0;
         tone_id <= 2'd0;
      end else if (w_timeout) begin
         r_run   <= '0;
         r_cand  <= 2'd0;
         tone_id <= 2'd0;
      end else if (period_valid) begin
         if (w_class == 2'd0) begin
            r_run   <= '0;
            r_cand  <= 2'd0;
            tone_id <= 2'd0;
         end else begin
            r_cand <= w_class;
            r_run  <= w_run_next;
            if (w_run_next >= c_min)
               tone_id <= w_class;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Alarm pattern FSM with segment timer
   // ---------------------------------------------------------------------
   state_t      r_state, w_state_next;
   logic [1:0]  r_tone_prev;
   logic [31:0] r_seg;
   logic        w_change;
   logic [7:0]  w_swc_inc, w_swc_next;

   assign w_change  = (tone_id != r_tone_prev);
   assign w_swc_inc = (switch_count == 8'hFF) ? 8'hFF : switch_count + 8'd1;

   always_comb begin
      w_state_next = r_state;
      w_swc_next   = switch_count;
      case (r_state)
         ST_IDLE: begin
            if (w_change && (tone_id != 2'd0)) begin
               w_state_next = ST_TRACK;
               w_swc_next   = 8'd0;
            end
         end
         ST_TRACK, ST_ALARM: begin
            if (tone_id == 2'd0) begin
               w_state_next = ST_IDLE;
               w_swc_next   = 8'd0;
            end else if (w_change) begin
               // Both old and new tone are nonzero here: a genuine switch.
               w_swc_next = w_swc_inc;
               if ((r_state == ST_TRACK) && (32'(w_swc_inc) >= 32'(SWITCHES_REQ)))
                  w_state_next = ST_ALARM;
            end else if (r_seg == c_seg_max) begin
               w_state_next = ST_IDLE;
               w_swc_next   = 8'd0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_swc_next   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_tone_prev  <= 2'd0;
         r_seg        <= '0;
         switch_count <= 8'd0;
      end else begin
         r_state      <= w_state_next;
         r_tone_prev  <= tone_id;
         switch_count <= w_swc_next;
         if (w_change)
            r_seg <= '0;
         else if (r_seg != c_seg_max)
            r_seg <= r_seg + 32'd1;
      end
   end

   assign alarm_detected = (r_state == ST_ALARM);

endmodule
`default_nettype wire

// File: tb/tb_tone_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_pattern_detector
//  Purpose  : Self-checking bench for tone_pattern_detector using scaled
//             parameters (P1=80, P2=20, T1=8, T2=2, PER_MAX=160,
//             SEG_MAX=2000) so every behaviour fits in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tone_pattern_detector;

   localparam int IN_CLK  = 8000;
   localparam int F1      = 100;
   localparam int F2      = 400;
   localparam int TEMPO   = 8;
   localparam int TOL     = 10;
   localparam int MINC    = 4;
   localparam int SWR     = 4;
   localparam int P1      = 80;
   localparam int T1      = 8;
   localparam int P2      = 20;
   localparam int T2      = 2;
   localparam int PER_MAX = 160;
   localparam int SEG_MAX = 2000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tone_in = 1'b0;
   logic [31:0] period;
   logic        period_valid;
   logic [1:0]  tone_id;
   logic [7:0]  switch_count;
   logic        alarm_detected;

   tone_pattern_detector #(
      .IN_CLK(IN_CLK), .FREQ1_HZ(F1), .FREQ2_HZ(F2), .TEMPO_HZ(TEMPO),
      .TOL_PCT(TOL), .MIN_CYCLES(MINC), .SWITCHES_REQ(SWR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tone_in(tone_in),
      .period(period), .period_valid(period_valid), .tone_id(tone_id),
      .switch_count(switch_count), .alarm_detected(alarm_detected)
   );

   always #5 clk = ~clk;

   longint ecount = 0;
   always @(posedge clk) ecount <= ecount + 1;

   typedef struct {
      int per;
      int tone;
      int swc;
      int alarm;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // ---------------- reference model (event/time based) ----------------
   bit     m_ref, m_act, m_alarm;
   longint m_prev, m_lc;
   int     m_run, m_cand, m_tone, m_swc;

   function automatic int classify(input int p);
      if (p >= P1 - T1 && p <= P1 + T1) return 1;
      if (p >= P2 - T2 && p <= P2 + T2) return 2;
      return 0;
   endfunction

   function automatic void model_reset();
      m_ref = 0; m_act = 0; m_alarm = 0;
      m_run = 0; m_cand = 0; m_tone = 0; m_swc = 0;
      m_prev = 0; m_lc = ecount;
      sb.delete();
   endfunction

   // Locked tone changes to v on clock edge e; pattern state is updated
   // as seen one edge later, after any segment expiry that came first.
   function automatic void tone_change(input longint e, input int v);
      if (m_act && (e + 1 > m_lc + 2 + SEG_MAX)) begin
         m_act = 0; m_alarm = 0; m_swc = 0;
      end
      if (!m_act) begin
         if (v != 0) begin m_act = 1; m_swc = 0; end
      end else if (v == 0) begin
         m_act = 0; m_alarm = 0; m_swc = 0;
      end else begin
         if (m_swc < 255) m_swc++;
         if (m_swc >= SWR) m_alarm = 1;
      end
      m_tone = v;
      m_lc   = e;
   endfunction

   // tone_in goes high before clock edge k.
   function automatic void model_rise(input longint k);
      int   p, c, nt;
      exp_t e;
      if (m_ref && (k - m_prev) > PER_MAX) begin
         m_ref = 0; m_run = 0; m_cand = 0;
         if (m_tone != 0) tone_change(m_prev + PER_MAX + 3, 0);
      end
      if (!m_ref) begin
         m_ref = 1; m_prev = k;
         return;
      end
      p = int'(k - m_prev);
      m_prev = k;
      c = classify(p);
      nt = m_tone;
      if (c == 0) begin
         m_run = 0; m_cand = 0; nt = 0;
      end else begin
         if (c == m_cand) begin
            if (m_run < MINC) m_run++;
         end else begin
            m_cand = c; m_run = 1;
         end
         if (m_run >= MINC) nt = c;
      end
      if (nt != m_tone)
         tone_change(k + 4, nt);
      else if (m_act && (k + 5 >= m_lc + 2 + SEG_MAX)) begin
         m_act = 0; m_alarm = 0; m_swc = 0;
      end
      e.per = p; e.tone = m_tone; e.swc = m_swc; e.alarm = int'(m_alarm);
      sb.push_back(e);
   endfunction

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && period_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_period_valid: got period %0d with no expected period (t=%0t)",
                        period, $time);
            end else begin
               e = sb.pop_front();
               check("period", period, e.per);
               @(negedge clk);
               check("tone_id", tone_id, e.tone);
               @(negedge clk);
               check("switch_count", switch_count, e.swc);
               check("alarm_detected", alarm_detected, e.alarm);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_period(input int p);
      int h;
      h = p / 2;
      tone_in = 1'b1;
      model_rise(ecount + 1);
      repeat (h) @(negedge clk);
      tone_in = 1'b0;
      repeat (p - h) @(negedge clk);
   endtask

   task automatic drive_n(input int n, input int p);
      repeat (n) drive_period(p);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_period"}, period, 0);
      check({tag, "_period_valid"}, period_valid, 0);
      check({tag, "_tone_id"}, tone_id, 0);
      check({tag, "_switch_count"}, switch_count, 0);
      check({tag, "_alarm"}, alarm_detected, 0);
   endtask

   task automatic release_reset();
      tone_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin : stim
      int kind, n, p;
      // Reset held with the input toggling.
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         tone_in = ~tone_in;
      end
      check_zero("reset");
      release_reset();

      // Tone 1 lock, then a double-rate tone that matches nothing.
      drive_n(8, P1);
      check("lock_tone1", tone_id, 1);
      check("no_alarm_tone1", alarm_detected, 0);
      drive_n(6, P1 / 2);
      check("double_rate_no_tone", tone_id, 0);

      // Tolerance boundaries.
      drive_n(6, P1 + T1);
      check("lock_at_upper_tol1", tone_id, 1);
      drive_n(5, P1 - T1);
      drive_period(P1 + T1 + 1);
      drive_n(5, P1 - T1);
      drive_period(P1 - T1 - 1);
      drive_n(6, P2 + T2);
      check("lock_at_upper_tol2", tone_id, 2);
      drive_n(5, P2 - T2);
      drive_period(P2 + T2 + 1);
      drive_n(5, P2 - T2);
      drive_period(P2 - T2 - 1);

      // Alternating pattern: enter on tone 1, then five switches.
      for (int s = 0; s < 6; s++)
         drive_n(6, (s % 2 == 0) ? P1 : P2);
      check("alarm_after_switches", alarm_detected, 1);
      check("switch_count_after_pattern", switch_count, 5);

      // Silence: period timeout drops everything.
      repeat (200) @(negedge clk);
      check("silence_tone_id", tone_id, 0);
      check("silence_switch_count", switch_count, 0);
      check("silence_alarm", alarm_detected, 0);

      // Steady tone 2 beyond the segment limit, then a switch re-enters fresh.
      drive_n(110, P2);
      check("steady_tone2", tone_id, 2);
      drive_n(6, P1);
      check("switch_after_steady_count", switch_count, 0);
      drive_n(6, P2);

      // Asynchronous reset in the middle of a locked tone.
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tone_in = ~tone_in;
      end
      release_reset();
      drive_n(6, P2);
      check("relock_after_reset", tone_id, 2);

      // Randomized bursts.
      repeat (40) begin
         kind = $urandom_range(0, 6);
         n    = $urandom_range(1, 8);
         if (kind == 3) n = $urandom_range(20, 30);
         for (int i = 0; i < n; i++) begin
            case (kind)
               0, 1:    p = $urandom_range(P1 - T1 - 2, P1 + T1 + 2);
               2, 4:    p = $urandom_range(P2 - T2 - 2, P2 + T2 + 2);
               3:       p = P1;
               default: p = $urandom_range(8, 200);
            endcase
            drive_period(p);
         end
      end

      repeat (10) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
